l1_l2_request_scheduler: RTL

//  Shares one core's L2 request port among three requesters: I-cache load miss queue, D-cache load miss queue
//  and store queue. Round-robin arbitration, single-entry output register with valid/ready handshake to L2,

---
 rtl/l1_l2_request_scheduler_if.sv | 72 +++++++
 rtl/l1_l2_request_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/l1_l2_request_scheduler_if.sv
// ----------------------------------------------------------------------------
// l1_l2_request_scheduler_if
// Bundles the three L1 requester handshakes (I-miss queue, D-miss queue,
// store queue), the single L2 request/response port and the outstanding
// credit count.
//   master : scheduler side. It drives the acks, the L2 request fields and
//            outstanding_count.
//   slave  : environment side. It drives the requests, l2_ready and
//            l2_response_valid.
// Parameters:
//   ADDR_WIDTH      : cache line index width
//   IDX_WIDTH       : miss/store entry index width
//   MAX_OUTSTANDING : sizes outstanding_count to $clog2(MAX_OUTSTANDING+1) bits
// ----------------------------------------------------------------------------
interface l1_l2_request_scheduler_if #(
  parameter int ADDR_WIDTH      = 26,
  parameter int IDX_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 8
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                  icache_ready;
  logic [ADDR_WIDTH-1:0] icache_addr;
  logic [IDX_WIDTH-1:0]  icache_idx;
  logic                  icache_ack;

  logic                  dcache_ready;
  logic [ADDR_WIDTH-1:0] dcache_addr;
  logic [IDX_WIDTH-1:0]  dcache_idx;
  logic                  dcache_synchronized;
  logic                  dcache_ack;

  logic                  sq_ready;
  logic [ADDR_WIDTH-1:0] sq_addr;
  logic [IDX_WIDTH-1:0]  sq_idx;
  logic                  sq_ack;

  logic                  l2_request_valid;
  logic [1:0]            l2_request_source;
  logic [ADDR_WIDTH-1:0] l2_request_addr;
  logic [IDX_WIDTH-1:0]  l2_request_idx;
  logic                  l2_request_sync;
  logic                  l2_ready;
  logic                  l2_response_valid;
  logic [CNT_W-1:0]      outstanding_count;

  modport master (
    input  icache_ready, icache_addr, icache_idx,
    output icache_ack,
    input  dcache_ready, dcache_addr, dcache_idx, dcache_synchronized,
    output dcache_ack,
    input  sq_ready, sq_addr, sq_idx,
    output sq_ack,
    output l2_request_valid, l2_request_source, l2_request_addr,
    output l2_request_idx, l2_request_sync,
    input  l2_ready, l2_response_valid,
    output outstanding_count
  );

  modport slave (
    output icache_ready, icache_addr, icache_idx,
    input  icache_ack,
    output dcache_ready, dcache_addr, dcache_idx, dcache_synchronized,
    input  dcache_ack,
    output sq_ready, sq_addr, sq_idx,
    input  sq_ack,
    input  l2_request_valid, l2_request_source, l2_request_addr,
    input  l2_request_idx, l2_request_sync,
    output l2_ready, l2_response_valid,
    input  outstanding_count
  );
endinterface

// File: rtl/l1_l2_request_scheduler.sv
// ----------------------------------------------------------------------------
// l1_l2_request_scheduler
// Shares one core's L2 request port among the I-cache miss queue, the D-cache
// miss queue and the store queue.
//
// Behaviour:
//   - Arbitration is round-robin.
//   - The request is held in a single-entry output register with a
//     valid/ready handshake to L2.
//   - The number of outstanding L2 transactions (accepted by L2 and not yet
//     responded) is limited by a credit count.
//
// Ports:
//   clk    : clock. All state changes on posedge.
//   reset  : synchronous, active-low. 0 clears all state and forces the acks
//            to 0.
//   bus    : l1_l2_request_scheduler_if.master.
//            - Requester ready/addr/idx inputs and their acks.
//            - L2 request fields and l2_ready.
//            - l2_response_valid and outstanding_count.
//
// Optional build macro L1_SCHED_PERF_COUNTERS_EN. When defined, it adds two
// registered one-cycle pulse outputs:
//   perf_credit_stall    : a requester was ready but credits were exhausted
//   perf_l2_backpressure : a request was held and L2 was not ready
// ----------------------------------------------------------------------------
module l1_l2_request_scheduler #(
  parameter int ADDR_WIDTH      = 26,
  parameter int IDX_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  l1_l2_request_scheduler_if.master       bus
`ifdef L1_SCHED_PERF_COUNTERS_EN
  ,
  output logic                            perf_credit_stall,
  output logic                            perf_l2_backpressure
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  // Round-robin pick. Bit 0 is icache, bit 1 is dcache, bit 2 is store.
  // The search starts at the pointer and wraps around.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] g;
    g = 3'b000;
    case (ptr)
      2'd1:    g = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      2'd2:    g = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
      default: g = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    endcase
    return g;
  endfunction

  state_t                state_p1;
  logic [1:0]            rr_ptr;
  logic [1:0]            src_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [IDX_WIDTH-1:0]  idx_p1;
  logic                  sync_p1;
  logic [CNT_W-1:0]      cnt;
  logic                  vld_p1;

  logic [2:0]            req_vec;
  logic [CNT_W:0]        credit_sum;
  logic                  credit_ok;
  logic                  can_load;
  logic [2:0]            grant;
  logic                  send;

  logic [1:0]            sel_src;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic                  sel_sync;
  logic [1:0]            nxt_ptr;

  assign vld_p1  = (state_p1 == HELD);
  assign req_vec = {bus.sq_ready, bus.dcache_ready, bus.icache_ready};

  // The held request counts against the credit limit because it will
  // consume a credit when it leaves. A response in this same cycle is not
  // credited here.
  assign credit_sum = {1'b0, cnt} + {{CNT_W{1'b0}}, vld_p1};
  assign credit_ok  = credit_sum < (CNT_W + 1)'(MAX_OUTSTANDING);
  assign can_load   = (!vld_p1 || bus.l2_ready) && credit_ok;
  assign grant      = can_load ? rr_pick(req_vec, rr_ptr) : 3'b000;
  assign send       = vld_p1 && bus.l2_ready;

  assign bus.icache_ack = grant[0] && reset;
  assign bus.dcache_ack = grant[1] && reset;
  assign bus.sq_ack     = grant[2] && reset;

  always_comb begin
    sel_src  = 2'd0;
    sel_addr = bus.icache_addr;
    sel_idx  = bus.icache_idx;
    sel_sync = 1'b0;
    nxt_ptr  = 2'd1;
    if (grant[1]) begin
      sel_src  = 2'd1;
      sel_addr = bus.dcache_addr;
      sel_idx  = bus.dcache_idx;
      sel_sync = bus.dcache_synchronized;
      nxt_ptr  = 2'd2;
    end else if (grant[2]) begin
      sel_src  = 2'd2;
      sel_addr = bus.sq_addr;
      sel_idx  = bus.sq_idx;
      nxt_ptr  = 2'd0;
    end
  end

  // ---- stage p1: output register, arbitration pointer, credit count ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_p1 <= EMPTY;
      rr_ptr   <= 2'd0;
      src_p1   <= 2'd0;
      addr_p1  <= '0;
      idx_p1   <= '0;
      sync_p1  <= 1'b0;
      cnt      <= '0;
`ifdef L1_SCHED_PERF_COUNTERS_EN
      perf_credit_stall    <= 1'b0;
      perf_l2_backpressure <= 1'b0;
`endif
    end else begin
      if (|grant) begin
        state_p1 <= HELD;
        rr_ptr   <= nxt_ptr;
        src_p1   <= sel_src;
        addr_p1  <= sel_addr;
        idx_p1   <= sel_idx;
        sync_p1  <= sel_sync;
      end else if (send) begin
        state_p1 <= EMPTY;
      end

      case ({send, bus.l2_response_valid})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
`ifdef L1_SCHED_PERF_COUNTERS_EN
      perf_credit_stall    <= (|req_vec) && !credit_ok;
      perf_l2_backpressure <= vld_p1 && !bus.l2_ready;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(bus.l2_response_valid && !send && cnt == '0));
      assert (cnt <= CNT_W'(MAX_OUTSTANDING));
    end
  end

  assign bus.l2_request_valid  = vld_p1;
  assign bus.l2_request_source = src_p1;
  assign bus.l2_request_addr   = addr_p1;
  assign bus.l2_request_idx    = idx_p1;
  assign bus.l2_request_sync   = sync_p1;
  assign bus.outstanding_count = cnt;

endmodule
